round_robin_arb: RTL and testbench
==================================

Name: round_robin_arb

Overview:
Parametrised N-way round-robin arbiter for shared-resource ownership, such as bus masters or cache ports. Grant is registered, one-hot plus encoded, with a valid flag.
- Per-requester lock keeps ownership.
- A hold limit bounds lock duration so no requester starves.
- Rotating priority pointer: the requester after the last grantee has highest priority.

Parameters:
NREQ, 8, number of requesters; legal 2..32.
HOLD_MAX, 16, max consecutive cycles a locked grant is held before forced re-arbitration; 0 = unlimited.
ENCW, $clog2(NREQ), encoded select width; derived, not overridden.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
ce  in  1  clock enable; state updates only when high
req  in  NREQ  request lines, one per requester
lock  in  NREQ  lock request; effective only for the bit matching current sel
sel  out  NREQ  grant, one-hot or zero, registered
sel_enc  out  ENCW  index of granted requester, registered
sel_vld  out  1  high when sel nonzero
hold_expired  out  1  one-cycle pulse: locked owner displaced by HOLD_MAX limit

Behaviour:
- Reset (async on rst high): sel=0, sel_enc=0, sel_vld=0, hold_expired=0, ptr=0, hold_cnt=0.
- ce low: all state and outputs frozen, except hold_expired, which clears on the next clk edge regardless of ce.
- State: ptr (ENCW bits, highest-priority index) and hold_cnt (counts held cycles, saturates at HOLD_MAX).
- held = sel_vld & |(lock & sel) & (HOLD_MAX==0 | hold_cnt < HOLD_MAX).
- Each ce cycle:
  - held: sel/sel_enc unchanged; hold_cnt++; ptr unchanged.
  - Otherwise arbitrate: search req from index ptr upward, wrapping NREQ-1 -> 0; first set bit k wins.
    - sel <= 1<<k; sel_enc <= k; sel_vld <= 1; ptr <= (k+1) mod NREQ; hold_cnt <= 0.
    - The mod wraps correctly for non-power-of-2 NREQ.
- Forced release (lock asserted but hold_cnt==HOLD_MAX):
  - Current owner's req is masked for that arbitration.
  - If another req exists, it wins and hold_expired <= 1 for one cycle.
  - If none, the owner is re-granted, hold_cnt <= 0, and hold_expired stays 0.
- No request and not held: sel <= 0, sel_enc <= 0, sel_vld <= 0; ptr and hold_cnt unchanged.
- Lock dominates req: a locked owner keeps the grant even if its req drops, within the hold limit.
- Lock bits for non-owners are ignored.
- Latency: req to sel is 1 clk when the arbiter is free. Grants are always one-hot. sel_enc always equals the index of sel, or 0 when sel_vld=0.
- rst mid-hold: immediate clear, priority pointer restarts at 0.

Optional Feature:
RR_WEIGHT_EN
- With the macro: adds parameter WT_W (default 3) and input wt [NREQ*WT_W].
  - Owner k also holds without lock while req[k] is high and burst_cnt < wt[k].
  - burst_cnt resets on each new grant.
  - This gives weighted fairness of up to wt[k]+1 consecutive cycles.
  - Lock hold and the HOLD_MAX limit are unchanged and take precedence.
- Without the macro: no wt port, no burst_cnt; every unlocked grant lasts one arbitration cycle.

Test Plan:
- Reset: NREQ=8, req=8'hFF during rst -> sel=0, sel_vld=0; after release grants cycle 0,1,2,...,7,0 one per cycle, sel_enc matching.
- Sparse rotation: req=8'b10010010 held -> grants 1,4,7,1,4,...; with req=0 -> sel=0, sel_vld=0, next grant resumes from ptr.
- Lock hold: HOLD_MAX=4, owner 2 with lock[2]=1, req=8'hFF -> sel=8'h04 for 4 held cycles, then grant 3 with hold_expired=1 for one cycle.
- Lone locked owner at limit: only req[5]/lock[5] set, HOLD_MAX=4 -> sel stays 8'h20 continuously, hold_expired never asserted.
- ce gating / async reset: ce=0 for 5 cycles -> outputs frozen; rst pulse mid-cycle during a hold -> outputs 0 before the next clk edge, ptr=0.
- RR_WEIGHT_EN: wt[0]=2, others 0, req=8'h03 -> sel pattern 0,0,0,1,0,0,0,1.

Source files
------------

// File: rtl/round_robin_arb.sv
// N-way round-robin arbiter with per-owner lock, bounded hold and registered one-hot/encoded grant.
// Optional weighted bursts are enabled by defining RR_WEIGHT_EN (adds parameter WT_W and input wt).
module round_robin_arb #(
    parameter int NREQ     = 8,
    parameter int HOLD_MAX = 16,
    parameter int ENCW     = $clog2(NREQ)
`ifdef RR_WEIGHT_EN
    ,
    parameter int WT_W     = 3
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
`ifdef RR_WEIGHT_EN
    input  logic [NREQ*WT_W-1:0] wt,
`endif
    output logic [NREQ-1:0] sel,
    output logic [ENCW-1:0] sel_enc,
    output logic            sel_vld,
    output logic            hold_expired
);

    localparam int HCW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    logic [NREQ-1:0] sel_q, sel_d;
    logic [ENCW-1:0] sel_enc_q, sel_enc_d;
    logic            sel_vld_q, sel_vld_d;
    logic            hold_expired_q, hold_expired_d;
    logic [ENCW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;

    logic            lock_own;
    logic            under_lim;
    logic            lock_held;
    logic            forced;
    logic            wt_held;
    logic [NREQ-1:0] req_eff;
    logic            found;
    int              win_idx;

`ifdef RR_WEIGHT_EN
    logic [WT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [WT_W-1:0] wt_own;

    // Unlocked owner keeps the grant for up to wt[k] extra cycles while it still requests.
    always_comb begin
        wt_own  = wt[int'(sel_enc_q)*WT_W +: WT_W];
        wt_held = sel_vld_q && !lock_own && |(req & sel_q) && (burst_cnt_q < wt_own);
    end
`else
    assign wt_held = 1'b0;
`endif

    // Lock ownership and the hold-limit decision for the current owner.
    always_comb begin
        lock_own  = sel_vld_q && |(lock & sel_q);
        under_lim = (HOLD_MAX == 0) || (int'(hold_cnt_q) < HOLD_MAX);
        lock_held = lock_own && under_lim;
        forced    = lock_own && !under_lim;
        req_eff   = forced ? (req & ~sel_q) : req;
    end

    // Circular search starting at ptr; the index wraps explicitly so any NREQ works.
    always_comb begin
        int idx;
        found   = 1'b0;
        win_idx = 0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_eff[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        int k;
        // NOTE: every _d gets a default before any branch so no path infers a latch.
        sel_d          = sel_q;
        sel_enc_d      = sel_enc_q;
        sel_vld_d      = sel_vld_q;
        ptr_d          = ptr_q;
        hold_cnt_d     = hold_cnt_q;
        hold_expired_d = 1'b0;
`ifdef RR_WEIGHT_EN
        burst_cnt_d    = burst_cnt_q;
`endif
        k              = found ? win_idx : int'(sel_enc_q);

        if (lock_held) begin
            if (HOLD_MAX != 0) hold_cnt_d = hold_cnt_q + HCW'(1);
        end else if (wt_held) begin
`ifdef RR_WEIGHT_EN
            burst_cnt_d = burst_cnt_q + WT_W'(1);
`endif
        end else if (found || forced) begin
            // A forced release with no competitor falls through to re-granting the owner.
            sel_d          = '0;
            sel_d[k]       = 1'b1;
            sel_enc_d      = ENCW'(k);
            sel_vld_d      = 1'b1;
            ptr_d          = ENCW'((k + 1) % NREQ);
            hold_cnt_d     = '0;
            hold_expired_d = forced && found;
`ifdef RR_WEIGHT_EN
            burst_cnt_d    = '0;
`endif
        end else begin
            sel_d     = '0;
            sel_enc_d = '0;
            sel_vld_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q          <= '0;
            sel_enc_q      <= '0;
            sel_vld_q      <= 1'b0;
            hold_expired_q <= 1'b0;
            ptr_q          <= '0;
            hold_cnt_q     <= '0;
`ifdef RR_WEIGHT_EN
            burst_cnt_q    <= '0;
`endif
        end else begin
            // The expiry pulse drops on every edge, even while ce holds the rest frozen.
            hold_expired_q <= 1'b0;
            if (ce) begin
                sel_q          <= sel_d;
                sel_enc_q      <= sel_enc_d;
                sel_vld_q      <= sel_vld_d;
                hold_expired_q <= hold_expired_d;
                ptr_q          <= ptr_d;
                hold_cnt_q     <= hold_cnt_d;
`ifdef RR_WEIGHT_EN
                burst_cnt_q    <= burst_cnt_d;
`endif
            end
        end
    end

    assign sel          = sel_q;
    assign sel_enc      = sel_enc_q;
    assign sel_vld      = sel_vld_q;
    assign hold_expired = hold_expired_q;

endmodule

// File: tb/tb_round_robin_arb.sv
// Directed bench for round_robin_arb: an 8-way instance with HOLD_MAX=4 and a 5-way unlimited-hold instance.
// The weighted-burst sequence is built only when RR_WEIGHT_EN is defined.
module tb_round_robin_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b1;
    logic [7:0] req = 8'hFF;
    logic [7:0] lock = 8'h00;
    logic [7:0] sel;
    logic [2:0] sel_enc;
    logic       sel_vld;
    logic       hold_expired;

    logic [4:0] req5 = 5'h00;
    logic [4:0] lock5 = 5'h00;
    logic [4:0] sel5;
    logic [2:0] sel_enc5;
    logic       sel_vld5;
    logic       hold_expired5;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef RR_WEIGHT_EN
    logic [23:0] wt  = 24'h000002;
    logic [14:0] wt5 = 15'h0000;
`endif

    always #5 clk = ~clk;

    round_robin_arb #(.NREQ(8), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .ce(ce), .req(req), .lock(lock),
`ifdef RR_WEIGHT_EN
        .wt(wt),
`endif
        .sel(sel), .sel_enc(sel_enc), .sel_vld(sel_vld), .hold_expired(hold_expired)
    );

    round_robin_arb #(.NREQ(5), .HOLD_MAX(0)) dut5 (
        .clk(clk), .rst(rst), .ce(ce), .req(req5), .lock(lock5),
`ifdef RR_WEIGHT_EN
        .wt(wt5),
`endif
        .sel(sel5), .sel_enc(sel_enc5), .sel_vld(sel_vld5), .hold_expired(hold_expired5)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_grant(input string tag, input int k);
        logic [7:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        check({tag, ".sel"}, 32'(sel), 32'(oh));
        check({tag, ".enc"}, 32'(sel_enc), 32'(k));
        check({tag, ".vld"}, 32'(sel_vld), 32'd1);
    endtask

    task automatic check_grant5(input string tag, input int k);
        logic [4:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        check({tag, ".sel5"}, 32'(sel5), 32'(oh));
        check({tag, ".enc5"}, 32'(sel_enc5), 32'(k));
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int expect_seq[5];
        // Reset held with all requests up.
        step();
        step();
        check("rst.sel", 32'(sel), 32'h0);
        check("rst.vld", 32'(sel_vld), 32'h0);
        check("rst.enc", 32'(sel_enc), 32'h0);
        check("rst.hexp", 32'(hold_expired), 32'h0);
        rst = 1'b0;

        // Full rotation 0..7 then back to 0.
        for (int i = 0; i < 9; i++) begin
            step();
            check_grant($sformatf("rot%0d", i), i % 8);
        end

        // Sparse rotation from ptr=1.
        req = 8'b1001_0010;
        expect_seq = '{1, 4, 7, 1, 4};
        for (int i = 0; i < 5; i++) begin
            step();
            check_grant($sformatf("sparse%0d", i), expect_seq[i]);
        end

        // Idle, then resume from ptr=5.
        req = 8'h00;
        step();
        check("idle.sel", 32'(sel), 32'h0);
        check("idle.vld", 32'(sel_vld), 32'h0);
        check("idle.enc", 32'(sel_enc), 32'h0);
        step();
        check("idle2.vld", 32'(sel_vld), 32'h0);
        req = 8'b1001_0010;
        step();
        check_grant("resume", 7);

        // Lock hold on owner 2 with HOLD_MAX=4.
        req  = 8'h04;
        lock = 8'h04;
        step();
        check_grant("lockgrant", 2);
        req = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step();
            check_grant($sformatf("held%0d", i), 2);
            check($sformatf("held%0d.hexp", i), 32'(hold_expired), 32'h0);
        end
        step();
        check_grant("expire", 3);
        check("expire.hexp", 32'(hold_expired), 32'h1);
        step();
        check_grant("after_expire", 4);
        check("after_expire.hexp", 32'(hold_expired), 32'h0);

        // Lone locked owner 5: re-granted at every limit, no expiry pulse.
        req  = 8'h20;
        lock = 8'h20;
        step();
        check_grant("lone.grant", 5);
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("lone%0d.sel", i), 32'(sel), 32'h20);
            check($sformatf("lone%0d.hexp", i), 32'(hold_expired), 32'h0);
        end

        // Competition appears with hold count at 2: two more held cycles, then displacement to 6.
        req = 8'hFF;
        step();
        check("comp0.sel", 32'(sel), 32'h20);
        step();
        check("comp1.sel", 32'(sel), 32'h20);
        step();
        check_grant("comp.expire", 6);
        check("comp.hexp", 32'(hold_expired), 32'h1);

        // ce low: grant frozen, expiry pulse still drops on the next edge.
        ce   = 1'b0;
        lock = 8'h00;
        step();
        check("ce0.hexp", 32'(hold_expired), 32'h0);
        check_grant("ce0", 6);
        for (int i = 1; i < 5; i++) begin
            step();
            check_grant($sformatf("ce%0d", i), 6);
        end

        // Async reset in the middle of a hold on owner 6.
        ce   = 1'b1;
        lock = 8'h40;
        step();
        check_grant("prehold", 6);
        #2 rst = 1'b1;
        #1;
        check("arst.sel", 32'(sel), 32'h0);
        check("arst.vld", 32'(sel_vld), 32'h0);
        check("arst.enc", 32'(sel_enc), 32'h0);
        #1 rst = 1'b0;
        step();
        check_grant("post_rst", 0);

        // Five-way instance: wrap from 4 back to 0, then unlimited lock.
        req  = 8'h00;
        lock = 8'h00;
        req5 = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            step();
            check_grant5($sformatf("n5rot%0d", i), i % 5);
        end
        req5  = 5'b00010;
        lock5 = 5'b00010;
        step();
        check_grant5("n5lock", 1);
        req5 = 5'b11111;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("n5hold%0d", i), 32'(sel5), 32'h02);
        end
        check("n5.hexp", 32'(hold_expired5), 32'h0);
        lock5 = 5'b00000;
        step();
        check_grant5("n5release", 2);

`ifdef RR_WEIGHT_EN
        // Weighted burst: wt[0]=2 gives owner 0 three cycles per turn.
        req5 = 5'b00000;
        rst  = 1'b1;
        #2 rst = 1'b0;
        req  = 8'h03;
        lock = 8'h00;
        expect_seq = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            step();
            check_grant($sformatf("wt%0d", i), expect_seq[i]);
        end
        expect_seq = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 3; i++) begin
            step();
            check_grant($sformatf("wt%0d", i + 5), expect_seq[i]);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
